// File: rtl/seq_comparator3.sv
// Digit-serial magnitude comparator. Operands arrive one 3-bit digit per accepted
// beat, least-significant digit first. A registered one-hot lt/et/gt result is produced.
module seq_comparator3 #(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       lt,
  output logic       et,
  output logic       gt,
  output logic [3:0] digit_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);
  localparam logic [2:0] CASC_EQ  = 3'b010;

  state_t     state_q;
  logic [2:0] casc_q;
  logic [2:0] casc_d;
  logic [2:0] res_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] idx_q;
  logic       beat;

  // A higher digit that differs overrides whatever the lower digits decided.
  function automatic logic [2:0] cascade_step(input logic [2:0] prev,
                                              input logic [2:0] a,
                                              input logic [2:0] b);
    if (a > b)      return 3'b001;
    else if (a < b) return 3'b100;
    else            return prev;
  endfunction

  assign beat = in_valid & in_ready_q;

  always_comb begin
    casc_d = cascade_step(casc_q, A, B);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      casc_q     <= CASC_EQ;
      res_q      <= CASC_EQ;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            casc_q     <= CASC_EQ;
            idx_q      <= 4'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (beat) begin
            casc_q <= casc_d;
            if (idx_q == LAST_IDX) begin
              // Result lands together with done; in_ready drops on this same edge.
              state_q    <= DONE;
              res_q      <= casc_d;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
              idx_q      <= 4'd0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lt        = res_q[2];
  assign et        = res_q[1];
  assign gt        = res_q[0];
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seq_comparator3.sv
// Directed bench for seq_comparator3 with DIGITS=4; the expected results are
// worked out by hand from the octal operands.
module tb_seq_comparator3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [2:0] A;
  logic [2:0] B;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       lt;
  logic       et;
  logic       gt;
  logic [3:0] digit_idx;

  int         total = 0;
  int         bad   = 0;
  logic [2:0] prev_res;

  seq_comparator3 #(.DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .lt        (lt),
    .et        (et),
    .gt        (gt),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full comparison. Optional stall cycles before each digit, and an optional
  // start pulse on the second beat.
  task automatic run_cmp(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input int stall, input bit start_mid, input logic [2:0] exp);
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("%s.run_entry", tag), {29'd0, in_ready, busy, done}, 32'b110);
    for (int d = 0; d < 4; d++) begin
      in_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk($sformatf("%s.stall_idx%0d", tag, d), {28'd0, digit_idx}, d);
        chk($sformatf("%s.stall_done%0d", tag, d), {31'd0, done}, 32'd0);
      end
      in_valid = 1'b1;
      A = a[3*d +: 3];
      B = b[3*d +: 3];
      start = start_mid && (d == 1);
      chk($sformatf("%s.idx%0d", tag, d), {28'd0, digit_idx}, d);
      chk($sformatf("%s.hold%0d", tag, d), {29'd0, lt, et, gt}, {29'd0, prev_res});
      chk($sformatf("%s.nodone%0d", tag, d), {31'd0, done}, 32'd0);
      step();
      start = 1'b0;
    end
    chk($sformatf("%s.done_flags", tag), {29'd0, in_ready, busy, done}, 32'b011);
    chk($sformatf("%s.result", tag), {29'd0, lt, et, gt}, {29'd0, exp});
    chk($sformatf("%s.idx_done", tag), {28'd0, digit_idx}, 32'd0);
    step();
    chk($sformatf("%s.idle_flags", tag), {29'd0, in_ready, busy, done}, 32'b000);
    chk($sformatf("%s.result_hold", tag), {29'd0, lt, et, gt}, {29'd0, exp});
    in_valid = 1'b0;
    prev_res = exp;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    A        = 3'd0;
    B        = 3'd0;
    prev_res = 3'b010;
    step();
    step();
    chk("reset.flags", {29'd0, in_ready, busy, done}, 32'b000);
    chk("reset.result", {29'd0, lt, et, gt}, 32'b010);
    chk("reset.idx", {28'd0, digit_idx}, 32'd0);
    reset = 1'b0;
    step();

    run_cmp("equal",    12'o1234, 12'o1234, 0, 1'b0, 3'b010);
    run_cmp("msb_dom",  12'o5000, 12'o4777, 0, 1'b0, 3'b001);
    run_cmp("lsb_lt",   12'o3332, 12'o3333, 0, 1'b0, 3'b100);
    run_cmp("lsb_gt",   12'o3334, 12'o3333, 0, 1'b0, 3'b001);

    // Asynchronous reset after two of four digits.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    A = 3'd1;
    B = 3'd0;
    step();
    step();
    in_valid = 1'b0;
    chk("midrst.idx_before", {28'd0, digit_idx}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.flags", {29'd0, in_ready, busy, done}, 32'b000);
    chk("midrst.result", {29'd0, lt, et, gt}, 32'b010);
    chk("midrst.idx", {28'd0, digit_idx}, 32'd0);
    reset = 1'b0;
    prev_res = 3'b010;
    step();
    run_cmp("after_rst", 12'o0123, 12'o0124, 0, 1'b0, 3'b100);

    run_cmp("stalls",    12'o0100, 12'o0010, 3, 1'b0, 3'b001);
    run_cmp("start_mid", 12'o1111, 12'o1111, 0, 1'b1, 3'b010);

    // in_valid while idle must not consume digits.
    in_valid = 1'b1;
    A = 3'd7;
    B = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_valid.flags%0d", i), {29'd0, in_ready, busy, done}, 32'b000);
      chk($sformatf("idle_valid.idx%0d", i), {28'd0, digit_idx}, 32'd0);
    end
    in_valid = 1'b0;
    step();

    run_cmp("b2b_first",  12'o7000, 12'o0777, 0, 1'b0, 3'b001);
    run_cmp("b2b_second", 12'o0777, 12'o7000, 0, 1'b0, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
